// File: rtl/pattern_round_controller.sv
// pattern_round_controller
//   Sequences one game round: requests a pattern set from the generator, latches it,
//   plays the first N patterns to the display with timed show/gap phases, then checks
//   keypad entries in order against the latched set and reports pass or fail.
//   N = 4 * (level + 1).
//
// Optional feature (macro ROUND_RETRY_EN): the first failure in the input phase replays
// the same latched set from index 0 instead of pulsing round_fail; a second failure fails.
//
// Ports
//   clk_1       system clock, rising edge
//   rst         asynchronous active-high reset
//   start       round start request, sampled only when idle
//   level       difficulty (latched on accepted start)
//   gen_end     generator done flag (level-sensitive)
//   patterns    packed 16 x 3-bit set, pattern k (1..16) at [3k-1:3k-3]
//   key_valid   one-cycle keypad strobe
//   key_code    keypad value, valid with key_valid
//   gen_en      generation request
//   busy        high in every state except idle
//   disp_valid  high while a pattern is shown
//   disp_code   shown pattern, 0 when disp_valid is low
//   disp_idx    index of shown pattern / expected entry
//   round_pass  one-cycle pulse on a fully correct sequence
//   round_fail  one-cycle pulse on a wrong entry or timeout
module pattern_round_controller #(
  parameter int unsigned SHOW_CYC    = 50,
  parameter int unsigned GAP_CYC     = 10,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  level,
  input  logic        gen_end,
  input  logic [47:0] patterns,
  input  logic        key_valid,
  input  logic [2:0]  key_code,
  output logic        gen_en,
  output logic        busy,
  output logic        disp_valid,
  output logic [2:0]  disp_code,
  output logic [3:0]  disp_idx,
  output logic        round_pass,
  output logic        round_fail
);

  localparam int unsigned MaxSG  = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int unsigned MaxCyc = (MaxSG > TIMEOUT_CYC) ? MaxSG : TIMEOUT_CYC;
  localparam int unsigned TimerW = $clog2(MaxCyc + 1);

  localparam logic [TimerW-1:0] ShowLast = TimerW'(SHOW_CYC - 1);
  localparam logic [TimerW-1:0] GapLast  = TimerW'(GAP_CYC - 1);
  localparam logic [TimerW-1:0] ToLast   = TimerW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StGen   = 3'd1;
  localparam logic [2:0] StShow  = 3'd2;
  localparam logic [2:0] StGap   = 3'd3;
  localparam logic [2:0] StInput = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [1:0]        lvl_q, lvl_d;
  logic [47:0]       set_q, set_d;
  logic [3:0]        idx_q, idx_d;
  logic [TimerW-1:0] timer_q, timer_d;

  logic              gen_en_d, busy_d, disp_valid_d, pass_d, fail_d;
  logic [2:0]        disp_code_d;
  logic [3:0]        disp_idx_d;

  logic [3:0]        last_idx;
  logic [2:0]        cur_code;
  logic              miss;

`ifdef ROUND_RETRY_EN
  logic              retry_q, retry_d;
`endif

  function automatic logic [2:0] pick(input logic [47:0] set, input logic [3:0] idx);
    logic [2:0] code;
    code = 3'd0;
    for (int k = 0; k < 16; k++) begin
      if (idx == 4'(k)) code = set[3*k +: 3];
    end
    return code;
  endfunction

  // N-1 = 4*level + 3
  assign last_idx = {lvl_q, 2'b11};
  assign cur_code = pick(set_q, idx_q);

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    set_d   = set_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    miss    = 1'b0;
`ifdef ROUND_RETRY_EN
    retry_d = retry_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          lvl_d   = level;
          idx_d   = 4'd0;
          timer_d = '0;
          state_d = StGen;
`ifdef ROUND_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      StGen: begin
        if (gen_end) begin
          set_d   = patterns;
          idx_d   = 4'd0;
          timer_d = '0;
          state_d = StShow;
        end
      end
      StShow: begin
        if (timer_q == ShowLast) begin
          timer_d = '0;
          state_d = StGap;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StGap: begin
        if (timer_q == GapLast) begin
          timer_d = '0;
          if (idx_q == last_idx) begin
            idx_d   = 4'd0;
            state_d = StInput;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StShow;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StInput: begin
        // A key in the timeout cycle wins over the timeout.
        if (key_valid) begin
          timer_d = '0;
          if (key_code == cur_code) begin
            if (idx_q == last_idx) begin
              pass_d  = 1'b1;
              idx_d   = 4'd0;
              state_d = StIdle;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else begin
            miss = 1'b1;
          end
        end else if (timer_q == ToLast) begin
          miss = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end

        if (miss) begin
          idx_d   = 4'd0;
          timer_d = '0;
`ifdef ROUND_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = StShow;
          end else begin
            fail_d  = 1'b1;
            state_d = StIdle;
          end
`else
          fail_d  = 1'b1;
          state_d = StIdle;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = 4'd0;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are derived from next state so the registered copies line up with the state.
  always_comb begin
    gen_en_d     = (state_d == StGen);
    busy_d       = (state_d != StIdle);
    disp_valid_d = (state_d == StShow);
    disp_code_d  = disp_valid_d ? pick(set_d, idx_d) : 3'd0;
    disp_idx_d   = (state_d == StIdle || state_d == StGen) ? 4'd0 : idx_d;
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      lvl_q      <= 2'd0;
      set_q      <= '0;
      idx_q      <= 4'd0;
      timer_q    <= '0;
      gen_en     <= 1'b0;
      busy       <= 1'b0;
      disp_valid <= 1'b0;
      disp_code  <= 3'd0;
      disp_idx   <= 4'd0;
      round_pass <= 1'b0;
      round_fail <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      set_q      <= set_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      gen_en     <= gen_en_d;
      busy       <= busy_d;
      disp_valid <= disp_valid_d;
      disp_code  <= disp_code_d;
      disp_idx   <= disp_idx_d;
      round_pass <= pass_d;
      round_fail <= fail_d;
    end
  end

`ifdef ROUND_RETRY_EN
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      retry_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_round_controller.sv
// Directed testbench for pattern_round_controller (SHOW_CYC=4, GAP_CYC=2, TIMEOUT_CYC=20).
// Expectations follow ROUND_RETRY_EN when the macro is defined for the build.
module tb_pattern_round_controller;

  localparam int unsigned ShowCyc = 4;
  localparam int unsigned GapCyc  = 2;
  localparam int unsigned ToCyc   = 20;

  logic        clk_1 = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  level;
  logic        gen_end;
  logic [47:0] patterns;
  logic        key_valid;
  logic [2:0]  key_code;
  logic        gen_en;
  logic        busy;
  logic        disp_valid;
  logic [2:0]  disp_code;
  logic [3:0]  disp_idx;
  logic        round_pass;
  logic        round_fail;

  int n_pass  = 0;
  int n_total = 0;
  int gcnt;

  localparam logic [47:0] P1 = 48'o7531;
  localparam logic [47:0] P4 = 48'o1234567012345670;
  localparam logic [47:0] P5 = 48'o76543210;

  pattern_round_controller #(
    .SHOW_CYC   (ShowCyc),
    .GAP_CYC    (GapCyc),
    .TIMEOUT_CYC(ToCyc)
  ) dut (
    .clk_1     (clk_1),
    .rst       (rst),
    .start     (start),
    .level     (level),
    .gen_end   (gen_end),
    .patterns  (patterns),
    .key_valid (key_valid),
    .key_code  (key_code),
    .gen_en    (gen_en),
    .busy      (busy),
    .disp_valid(disp_valid),
    .disp_code (disp_code),
    .disp_idx  (disp_idx),
    .round_pass(round_pass),
    .round_fail(round_fail)
  );

  always #5 clk_1 = ~clk_1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_1);
    @(negedge clk_1);
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] code_of(input logic [47:0] pat, input int k);
    logic [47:0] p;
    p = pat >> (3 * k);
    return p[2:0];
  endfunction

  task automatic all_zero(input string tag);
    chk(tag, {gen_en, busy, disp_valid, disp_code, disp_idx, round_pass, round_fail}, 48'd0);
  endtask

  // Start a round; gen_end is raised after `delay` GEN cycles. Ends on the first SHOW cycle.
  task automatic begin_round(input logic [1:0] lv, input logic [47:0] pat, input int delay,
                             output int cnt);
    level    = lv;
    patterns = pat;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("gen_rise", {gen_en, busy}, 48'b11);
    cnt = 0;
    for (int i = 0; i < delay; i++) begin
      if (gen_en === 1'b1) cnt++;
      step();
    end
    gen_end = 1'b1;
    if (gen_en === 1'b1) cnt++;
    step();
    gen_end = 1'b0;
  endtask

  task automatic play(input int n, input logic [47:0] pat);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < int'(ShowCyc); c++) begin
        chk($sformatf("show k=%0d c=%0d", k, c), {gen_en, disp_valid, disp_idx, disp_code},
            {1'b0, 1'b1, 4'(k), code_of(pat, k)});
        step();
      end
      for (int g = 0; g < int'(GapCyc); g++) begin
        chk($sformatf("gap k=%0d g=%0d", k, g), {gen_en, disp_valid, disp_code}, 48'd0);
        step();
      end
    end
  endtask

  task automatic key(input logic [2:0] c);
    key_valid = 1'b1;
    key_code  = c;
    step();
    key_valid = 1'b0;
  endtask

  // Idle in INPUT with no keys; returns on the cycle after the timeout edge.
  task automatic wait_timeout();
    for (int i = 0; i < int'(ToCyc); i++) begin
      chk($sformatf("input_wait %0d", i), {round_fail, busy, disp_idx}, {1'b0, 1'b1, 4'd0});
      step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    level     = 2'd0;
    gen_end   = 1'b0;
    patterns  = '0;
    key_valid = 1'b0;
    key_code  = 3'd0;
    step();
    step();
    all_zero("reset");
    rst = 1'b0;
    step();
    all_zero("idle_after_reset");

    // Scenario 1/2: level 0, gen_end after 3 GEN cycles, correct keys
    begin_round(2'd0, P1, 3, gcnt);
    chk("gen_en_cycles", 48'(gcnt), 48'd4);
    play(4, P1);
    chk("input_entry", {busy, disp_valid, disp_idx, round_pass, round_fail}, {1'b1, 1'b0, 4'd0,
        1'b0, 1'b0});
    key(3'd1);
    chk("key1", {disp_idx, round_pass, round_fail}, {4'd1, 1'b0, 1'b0});
    key(3'd3);
    key(3'd5);
    chk("key5", {disp_idx, round_pass, round_fail}, {4'd3, 1'b0, 1'b0});
    key(3'd7);
    chk("pass_pulse", {round_pass, round_fail, busy}, 48'b100);
    step();
    chk("pass_end", {round_pass, round_fail, busy}, 48'b000);

    // Scenario 3/6: gen_end already high when GEN is entered, wrong third key
    gen_end = 1'b1;
    begin_round(2'd0, P1, 0, gcnt);
    chk("gen_en_immediate", 48'(gcnt), 48'd1);
    play(4, P1);
    key(3'd1);
    key(3'd3);
    key(3'd6);
`ifdef ROUND_RETRY_EN
    chk("retry_replay", {round_fail, busy, disp_valid, disp_idx, gen_en},
        {1'b0, 1'b1, 1'b1, 4'd0, 1'b0});
    play(4, P1);
    key(3'd2);
    chk("retry_fail", {round_fail, round_pass, busy}, 48'b100);
`else
    chk("fail_pulse", {round_fail, round_pass, busy}, 48'b100);
`endif
    step();
    chk("fail_end", round_fail, 48'd0);
    key(3'd7);
    chk("key_ignored_idle", {round_pass, round_fail, busy, disp_idx}, 48'd0);

    // Scenario 4: level 3, inputs changed after latching, timeout
    begin_round(2'd3, P4, 2, gcnt);
    level    = 2'd0;
    patterns = '0;
    play(16, P4);
    wait_timeout();
`ifdef ROUND_RETRY_EN
    chk("timeout_retry", {round_fail, busy, disp_valid, disp_idx}, {1'b0, 1'b1, 1'b1, 4'd0});
    play(16, P4);
    wait_timeout();
`endif
    chk("timeout_fail", {round_fail, busy}, 48'b10);
    step();
    chk("timeout_end", {round_fail, busy}, 48'b00);

    // Scenario 5: async reset mid-SHOW at idx 2, ignored start/key, then a normal round
    begin_round(2'd0, P1, 1, gcnt);
    play(2, P1);
    chk("show_idx2", {disp_valid, disp_idx, disp_code}, {1'b1, 4'd2, 3'd5});
    start     = 1'b1;
    key_valid = 1'b1;
    key_code  = 3'd5;
    step();
    start     = 1'b0;
    key_valid = 1'b0;
    chk("start_ignored", {gen_en, busy, disp_valid, disp_idx, disp_code},
        {1'b0, 1'b1, 1'b1, 4'd2, 3'd5});
    #2 rst = 1'b1;
    #1 all_zero("async_reset");
    step();
    step();
    rst = 1'b0;
    step();
    all_zero("idle_after_abort");

    begin_round(2'd1, P5, 0, gcnt);
    play(8, P5);
    for (int i = 0; i < 7; i++) begin
      key(3'(i));
      chk($sformatf("l1_key%0d", i), {disp_idx, round_pass, round_fail, busy},
          {4'(i + 1), 1'b0, 1'b0, 1'b1});
    end
    key(3'd7);
    chk("l1_pass", {round_pass, round_fail, busy}, 48'b100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
